// File: rtl/sfi_axi_rd_bridge.sv
// SFI-to-AXI read bridge: SFI read requests become AXI AR bursts, and R beats return as SFI responses tagged with the owning transid.
// Latency: request accept -> axi_arvalid 1 cycle; R beat -> SFI response is a combinational pass-through (0 cycles).
// Backpressure: requests stall while every slot is busy or the AR register is stalled; R follows sfi_rsp_rdy, and unknown-id beats are sunk.
module sfi_axi_rd_bridge #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 40,
    parameter int TID_W  = 8,
    parameter int ID_W   = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    // SFI request
    input  logic              sfi_req_vld,
    output logic              sfi_req_rdy,
    input  logic [5:0]        sfi_req_length,
    input  logic [ADDR_W-1:0] sfi_req_addr,
    input  logic [TID_W-1:0]  sfi_req_transid,
    // SFI response
    output logic              sfi_rsp_vld,
    input  logic              sfi_rsp_rdy,
    output logic              sfi_rsp_last,
    output logic              sfi_rsp_status,
    output logic [TID_W-1:0]  sfi_rsp_transid,
    output logic [DATA_W-1:0] sfi_rsp_data,
    // AXI AR
    output logic              axi_arvalid,
    input  logic              axi_arready,
    output logic [ID_W-1:0]   axi_arid,
    output logic [ADDR_W-1:0] axi_araddr,
    output logic [7:0]        axi_arlen,
    // AXI R
    input  logic              axi_rvalid,
    output logic              axi_rready,
    input  logic [ID_W-1:0]   axi_rid,
    input  logic [DATA_W-1:0] axi_rdata,
    input  logic [1:0]        axi_rresp,
    input  logic              axi_rlast,
    // status
    output logic              err_unexp
);

    localparam int IDX_W = $clog2(DEPTH);

    // Slot table: the slot index doubles as the AXI id of the burst.
    logic [DEPTH-1:0] r_slot_vld;
    logic [TID_W-1:0] r_slot_tid [DEPTH];
    logic [5:0]       r_slot_len [DEPTH];
    logic [5:0]       r_slot_cnt [DEPTH];

    // AR output register
    logic              r_arvalid;
    logic [ID_W-1:0]   r_arid;
    logic [ADDR_W-1:0] r_araddr;
    logic [7:0]        r_arlen;

    logic             w_any_free;
    logic [IDX_W-1:0] w_free_idx;
    logic             w_req_acc;
    logic [IDX_W-1:0] w_ridx;
    logic             w_rid_in_range;
    logic             w_rid_hit;
    logic             w_cnt_done;
    logic             w_rsp_last;
    logic             w_beat_acc;

    // Lowest-index free slot. This uses registered state only, so a slot freed
    // this cycle cannot be reallocated until the next cycle.
    always_comb begin
        w_any_free = 1'b0;
        w_free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_slot_vld[i]) begin
                w_any_free = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    assign sfi_req_rdy = w_any_free & (~r_arvalid | axi_arready);
    assign w_req_acc   = sfi_req_vld & sfi_req_rdy;

    // An id whose bits above the slot index are nonzero can never be
    // outstanding. DEPTH is a power of two, so checking those bits is enough.
    assign w_ridx         = axi_rid[IDX_W-1:0];
    assign w_rid_in_range = ((axi_rid >> IDX_W) == '0);
    assign w_rid_hit      = w_rid_in_range & r_slot_vld[w_ridx];
    assign w_cnt_done     = (r_slot_cnt[w_ridx] == r_slot_len[w_ridx]);
    assign w_rsp_last     = axi_rlast | w_cnt_done;
    assign w_beat_acc     = axi_rvalid & w_rid_hit & sfi_rsp_rdy;

    // Beats for an owned id pass through untouched. Stray beats are sunk
    // (rready forced high) and flagged.
    assign sfi_rsp_vld     = axi_rvalid & w_rid_hit;
    assign axi_rready      = w_rid_hit ? sfi_rsp_rdy : 1'b1;
    assign sfi_rsp_last    = w_rsp_last;
    assign sfi_rsp_status  = (axi_rresp != 2'b00) | (axi_rlast & ~w_cnt_done);
    assign sfi_rsp_transid = r_slot_tid[w_ridx];
    assign sfi_rsp_data    = axi_rdata;
    assign err_unexp       = axi_rvalid & ~w_rid_hit & ~reset;

    // Slot bookkeeping. An allocation and a free in the same cycle always
    // target different slots: one slot is currently free, the other is valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_slot_tid[i] <= '0;
                r_slot_len[i] <= '0;
                r_slot_cnt[i] <= '0;
            end
        end else begin
            if (w_beat_acc) begin
                if (w_rsp_last) begin
                    r_slot_vld[w_ridx] <= 1'b0;
                end else begin
                    r_slot_cnt[w_ridx] <= r_slot_cnt[w_ridx] + 6'd1;
                end
            end
            if (w_req_acc) begin
                r_slot_vld[w_free_idx] <= 1'b1;
                r_slot_tid[w_free_idx] <= sfi_req_transid;
                r_slot_len[w_free_idx] <= sfi_req_length;
                r_slot_cnt[w_free_idx] <= 6'd0;
            end
        end
    end

    // AR register: loads on accept and holds while stalled. Accept is only
    // possible when the register is empty or draining, so a stalled payload
    // is never overwritten.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_arvalid <= 1'b0;
            r_arid    <= '0;
            r_araddr  <= '0;
            r_arlen   <= '0;
        end else if (w_req_acc) begin
            r_arvalid <= 1'b1;
            r_arid    <= ID_W'(w_free_idx);
            r_araddr  <= sfi_req_addr;
            r_arlen   <= {2'b00, sfi_req_length};
        end else if (axi_arready) begin
            r_arvalid <= 1'b0;
        end
    end

    assign axi_arvalid = r_arvalid;
    assign axi_arid    = r_arid;
    assign axi_araddr  = r_araddr;
    assign axi_arlen   = r_arlen;

endmodule

// File: tb/tb_sfi_axi_rd_bridge.sv
// Testbench for sfi_axi_rd_bridge: directed scenarios followed by a randomized phase.
// Expected responses come from a table of outstanding reads keyed by AXI id.
// Inputs are driven 1 time unit after the rising edge and sampled 1 time unit later.
module tb_sfi_axi_rd_bridge;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 40;
    localparam int TID_W  = 8;
    localparam int ID_W   = 4;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              sfi_req_vld;
    logic              sfi_req_rdy;
    logic [5:0]        sfi_req_length;
    logic [ADDR_W-1:0] sfi_req_addr;
    logic [TID_W-1:0]  sfi_req_transid;
    logic              sfi_rsp_vld;
    logic              sfi_rsp_rdy;
    logic              sfi_rsp_last;
    logic              sfi_rsp_status;
    logic [TID_W-1:0]  sfi_rsp_transid;
    logic [DATA_W-1:0] sfi_rsp_data;
    logic              axi_arvalid;
    logic              axi_arready;
    logic [ID_W-1:0]   axi_arid;
    logic [ADDR_W-1:0] axi_araddr;
    logic [7:0]        axi_arlen;
    logic              axi_rvalid;
    logic              axi_rready;
    logic [ID_W-1:0]   axi_rid;
    logic [DATA_W-1:0] axi_rdata;
    logic [1:0]        axi_rresp;
    logic              axi_rlast;
    logic              err_unexp;

    sfi_axi_rd_bridge #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TID_W(TID_W), .ID_W(ID_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .sfi_req_vld(sfi_req_vld), .sfi_req_rdy(sfi_req_rdy),
        .sfi_req_length(sfi_req_length), .sfi_req_addr(sfi_req_addr),
        .sfi_req_transid(sfi_req_transid),
        .sfi_rsp_vld(sfi_rsp_vld), .sfi_rsp_rdy(sfi_rsp_rdy),
        .sfi_rsp_last(sfi_rsp_last), .sfi_rsp_status(sfi_rsp_status),
        .sfi_rsp_transid(sfi_rsp_transid), .sfi_rsp_data(sfi_rsp_data),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rid(axi_rid),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Table of outstanding reads, one entry per AXI id (ids >= DEPTH stay empty).
    bit         mdl_vld  [16];
    logic [7:0] mdl_tid  [16];
    int         mdl_len  [16];
    int         mdl_seen [16];

    int          outq[$];
    logic [63:0] rnd64;
    logic [1:0]  rnd_resp;
    int          pick;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int mdl_lowest_free();
        for (int i = 0; i < DEPTH; i++) if (!mdl_vld[i]) return i;
        return -1;
    endfunction

    function automatic int mdl_busy();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (mdl_vld[i]) n++;
        return n;
    endfunction

    task automatic mdl_clear();
        for (int i = 0; i < 16; i++) begin
            mdl_vld[i]  = 1'b0;
            mdl_seen[i] = 0;
        end
    endtask

    // Present one request, wait (bounded) for ready, then check the AR that follows.
    task automatic send_req(input logic [5:0] len, input logic [7:0] tid, input logic [ADDR_W-1:0] addr);
        int eid;
        int n;
        sfi_req_length  = len;
        sfi_req_transid = tid;
        sfi_req_addr    = addr;
        sfi_req_vld     = 1'b1;
        #1;
        n = 0;
        while (!sfi_req_rdy && n < 100) begin
            tick();
            n++;
        end
        chk("req_rdy_wait", sfi_req_rdy, 1'b1);
        eid = mdl_lowest_free();
        tick();
        sfi_req_vld = 1'b0;
        if (eid >= 0) begin
            mdl_vld[eid]  = 1'b1;
            mdl_tid[eid]  = tid;
            mdl_len[eid]  = int'(len);
            mdl_seen[eid] = 0;
        end
        chk("ar_valid", axi_arvalid, 1'b1);
        chk("ar_id",    axi_arid,    eid);
        chk("ar_addr",  axi_araddr,  addr);
        chk("ar_len",   axi_arlen,   len);
    endtask

    // Drive one R beat and check the SFI side against the outstanding-read table.
    task automatic r_beat(input int id, input logic [63:0] data, input logic [1:0] resp,
                          input bit last, input bit stall);
        bit hit;
        bit exp_last;
        bit exp_st;
        hit         = mdl_vld[id];
        axi_rvalid  = 1'b1;
        axi_rid     = ID_W'(id);
        axi_rdata   = data;
        axi_rresp   = resp;
        axi_rlast   = last;
        sfi_rsp_rdy = !(stall && hit);
        #1;
        if (stall && hit) begin
            chk("r_stall_rready",  axi_rready,  1'b0);
            chk("r_stall_rsp_vld", sfi_rsp_vld, 1'b1);
            tick();
            sfi_rsp_rdy = 1'b1;
            #1;
        end
        exp_last = last || (mdl_seen[id] == mdl_len[id]);
        exp_st   = (resp != 2'b00) || (last && mdl_seen[id] != mdl_len[id]);
        if (hit) begin
            chk("rsp_vld",     sfi_rsp_vld,     1'b1);
            chk("rsp_rready",  axi_rready,      1'b1);
            chk("rsp_transid", sfi_rsp_transid, mdl_tid[id]);
            chk("rsp_data",    sfi_rsp_data,    data);
            chk("rsp_last",    sfi_rsp_last,    exp_last);
            chk("rsp_status",  sfi_rsp_status,  exp_st);
            chk("rsp_err",     err_unexp,       1'b0);
        end else begin
            chk("stray_rsp_vld", sfi_rsp_vld, 1'b0);
            chk("stray_rready",  axi_rready,  1'b1);
            chk("stray_err",     err_unexp,   1'b1);
        end
        tick();
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
        if (hit) begin
            if (exp_last) mdl_vld[id] = 1'b0;
            else mdl_seen[id]++;
        end
        #1;
        if (!hit) chk("stray_err_pulse_end", err_unexp, 1'b0);
    endtask

    // Deliver the remaining beats of every outstanding read in id order.
    task automatic drain();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) begin
            while (mdl_vld[i] && n < 500) begin
                rnd64 = {$urandom, $urandom};
                r_beat(i, rnd64, 2'b00, mdl_seen[i] == mdl_len[i], 1'b0);
                n++;
            end
        end
        chk("drain_done", mdl_busy(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        mdl_clear();
        reset           = 1'b1;
        sfi_req_vld     = 1'b0;
        sfi_req_length  = '0;
        sfi_req_addr    = '0;
        sfi_req_transid = '0;
        sfi_rsp_rdy     = 1'b1;
        axi_arready     = 1'b1;
        axi_rvalid      = 1'b1;      // stray beat while in reset must stay silent
        axi_rid         = '0;
        axi_rdata       = '0;
        axi_rresp       = '0;
        axi_rlast       = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arvalid", axi_arvalid, 1'b0);
        chk("rst_rsp_vld", sfi_rsp_vld, 1'b0);
        chk("rst_err",     err_unexp,   1'b0);
        chk("rst_araddr",  axi_araddr,  '0);
        chk("rst_arid",    axi_arid,    '0);
        chk("rst_arlen",   axi_arlen,   '0);
        axi_rvalid = 1'b0;
        reset      = 1'b0;
        #1;
        chk("post_rst_req_rdy", sfi_req_rdy, 1'b1);
        chk("post_rst_arvalid", axi_arvalid, 1'b0);
        chk("post_rst_rsp_vld", sfi_rsp_vld, 1'b0);
        tick();

        // Single 4-beat read, with one stalled response beat
        send_req(6'd3, 8'h5A, 40'h1000);
        tick();
        chk("ar_drop_after_hs", axi_arvalid, 1'b0);
        r_beat(0, 64'h1111_0000_0000_0001, 2'b00, 1'b0, 1'b0);
        r_beat(0, 64'h2222_0000_0000_0002, 2'b00, 1'b0, 1'b1);
        r_beat(0, 64'h3333_0000_0000_0003, 2'b00, 1'b0, 1'b0);
        r_beat(0, 64'h4444_0000_0000_0004, 2'b00, 1'b1, 1'b0);
        chk("single_freed", mdl_busy(), 0);

        // Out-of-order return across ids
        send_req(6'd0, 8'h10, 40'h2000);
        send_req(6'd0, 8'h11, 40'h2040);
        r_beat(1, 64'hAAAA, 2'b00, 1'b1, 1'b0);
        r_beat(0, 64'hBBBB, 2'b00, 1'b1, 1'b0);

        // Stray beats: a free slot id, and an id beyond the table
        r_beat(3, 64'hDEAD, 2'b00, 1'b1, 1'b0);
        r_beat(9, 64'hBEEF, 2'b00, 1'b0, 1'b0);

        // Early rlast: the beat is marked last with error status, and later beats are stray
        send_req(6'd3, 8'h77, 40'h3000);
        r_beat(0, 64'h1, 2'b00, 1'b0, 1'b0);
        r_beat(0, 64'h2, 2'b00, 1'b1, 1'b0);
        chk("early_last_freed", mdl_vld[0], 1'b0);
        r_beat(0, 64'h3, 2'b00, 1'b0, 1'b0);

        // Error response status
        send_req(6'd0, 8'h78, 40'h3100);
        r_beat(0, 64'h4, 2'b10, 1'b1, 1'b0);

        // Fill every slot, hold a fifth request, free slot 2, and check that it is reused
        send_req(6'd1, 8'hC0, 40'h4000);
        send_req(6'd1, 8'hC1, 40'h4100);
        send_req(6'd0, 8'hC2, 40'h4200);
        send_req(6'd1, 8'hC3, 40'h4300);
        chk("full_req_rdy", sfi_req_rdy, 1'b0);
        sfi_req_vld     = 1'b1;
        sfi_req_length  = 6'd0;
        sfi_req_transid = 8'hC4;
        sfi_req_addr    = 40'h4400;
        tick();
        chk("full_req_rdy_hold", sfi_req_rdy, 1'b0);
        chk("full_ar_dropped",   axi_arvalid, 1'b0);
        r_beat(2, 64'h22, 2'b00, 1'b1, 1'b0);
        chk("slot2_free_rdy", sfi_req_rdy, 1'b1);
        send_req(6'd0, 8'hC4, 40'h4400);
        drain();

        // AR stall: payload holds and requests are blocked
        axi_arready = 1'b0;
        send_req(6'd2, 8'h33, 40'hABC0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_req_rdy", sfi_req_rdy, 1'b0);
            chk("stall_arvalid", axi_arvalid, 1'b1);
            chk("stall_araddr",  axi_araddr,  40'hABC0);
            chk("stall_arlen",   axi_arlen,   8'd2);
        end
        axi_arready = 1'b1;
        #1;
        chk("unstall_req_rdy", sfi_req_rdy, 1'b1);
        tick();
        chk("unstall_ar_drop", axi_arvalid, 1'b0);
        drain();

        // Reset mid-transaction discards outstanding reads
        send_req(6'd1, 8'h44, 40'h5000);
        reset = 1'b1;
        #2;
        chk("midrst_arvalid", axi_arvalid, 1'b0);
        mdl_clear();
        reset = 1'b0;
        tick();
        chk("midrst_req_rdy", sfi_req_rdy, 1'b1);
        r_beat(0, 64'h55, 2'b00, 1'b0, 1'b0);

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            int nreq;
            int nb;
            nreq = $urandom_range(0, DEPTH - mdl_busy());
            for (int k = 0; k < nreq; k++) begin
                rnd64 = {$urandom, $urandom};
                send_req(6'($urandom_range(0, 3)), 8'($urandom), rnd64[ADDR_W-1:0]);
            end
            nb = $urandom_range(1, 6);
            for (int b = 0; b < nb; b++) begin
                outq.delete();
                for (int i = 0; i < DEPTH; i++) if (mdl_vld[i]) outq.push_back(i);
                if ($urandom_range(0, 7) == 0 || outq.size() == 0) pick = $urandom_range(0, 15);
                else pick = outq[$urandom_range(0, outq.size() - 1)];
                rnd64    = {$urandom, $urandom};
                rnd_resp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                r_beat(pick, rnd64, rnd_resp,
                       (mdl_seen[pick] == mdl_len[pick]) || ($urandom_range(0, 7) == 0),
                       $urandom_range(0, 3) == 0);
            end
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sfi_axi_rd_bridge.md
SFI_AXI_RD_BRIDGE -- requirements
Module: sfi_axi_rd_bridge

Interface
REQ-001 Param DATA_W, 64, data width of SFI response and AXI R.
REQ-002 Param ADDR_W, 40, address width.
REQ-003 Param TID_W, 8, SFI transid width.
REQ-004 Param ID_W, 4, AXI ID width.
REQ-005 Param DEPTH, 4, max outstanding reads; power of 2, 2 <= DEPTH <= 2^ID_W.
REQ-006 Port clk  in  1  sole clock, rising edge.
REQ-007 Port reset  in  1  asynchronous, active-high reset.
REQ-008 Port sfi_req_vld  in  1  SFI read request valid.
REQ-009 Port sfi_req_rdy  out  1  SFI request accepted when vld&rdy.
REQ-010 Port sfi_req_length  in  6  beats minus one.
REQ-011 Port sfi_req_addr  in  ADDR_W  start address.
REQ-012 Port sfi_req_transid  in  TID_W  SFI transaction id.
REQ-013 Port sfi_rsp_vld  out  1  response beat valid.
REQ-014 Port sfi_rsp_rdy  in  1  response beat accepted.
REQ-015 Port sfi_rsp_last  out  1  final beat of transaction.
REQ-016 Port sfi_rsp_status  out  1  1 = error.
REQ-017 Port sfi_rsp_transid  out  TID_W  transid of owning request.
REQ-018 Port sfi_rsp_data  out  DATA_W  read data.
REQ-019 Port axi_arvalid  out  1  AR valid.
REQ-020 Port axi_arready  in  1  AR ready.
REQ-021 Port axi_arid  out  ID_W  slot index, zero-extended.
REQ-022 Port axi_araddr  out  ADDR_W  AR address.
REQ-023 Port axi_arlen  out  8  AR burst length, zero-extended sfi_req_length.
REQ-024 Port axi_rvalid / axi_rready  in / out  1 / 1  R handshake.
REQ-025 Port axi_rid  in  ID_W  R id.
REQ-026 Port axi_rdata / axi_rresp / axi_rlast  in  DATA_W / 2 / 1  R payload.
REQ-027 Port err_unexp  out  1  one-cycle pulse on R beat for an unallocated id.

Function
REQ-028 Slot table of DEPTH entries; each entry holds valid, transid, len, and a 6-bit beat counter.
REQ-029 sfi_req_rdy SHALL be 1 iff at least one slot is free and (axi_arvalid==0 or axi_arready==1).
REQ-030 On request accept, the lowest-index free slot SHALL be allocated (transid, len stored, counter=0), and the AR register SHALL be loaded next cycle (arid=slot, araddr, arlen); latency req-accept to arvalid = 1 cycle.
REQ-031 AR payload SHALL be held stable while arvalid=1 and arready=0; arvalid drops the cycle after the handshake unless a new request loads it.
REQ-032 R path SHALL be combinational pass-through: sfi_rsp_vld = rvalid & slot[rid].valid; data, transid = slot[rid].transid.
REQ-033 axi_rready = sfi_rsp_rdy when slot[rid].valid, else 1 (beat dropped, err_unexp pulses).
REQ-034 sfi_rsp_status = (rresp != 0) or beat-count mismatch (rlast on beat != len).
REQ-035 sfi_rsp_last = rlast or (counter == len); on that beat's handshake the slot SHALL be freed; later beats for the freed id are treated per REQ-033.
REQ-036 Counter increments on each accepted beat; it does not wrap, as the slot frees at counter==len.
REQ-037 Responses for different ids are returned in AXI arrival order; no reordering.
REQ-038 Same-cycle alloc and free SHALL both occur. Free-slot selection uses registered state, so a slot freed this cycle is reusable next cycle.
REQ-039 With all DEPTH slots valid, sfi_req_rdy = 0 until a slot frees.

Reset
REQ-040 While reset=1: all slots invalid; arvalid=0, sfi_rsp_vld=0, err_unexp=0, araddr/arid/arlen=0; reset mid-transaction discards all outstanding state.
REQ-041 First cycle after reset deassertion: sfi_req_rdy=1.

Verification
REQ-042 Reset release -> sfi_req_rdy=1, axi_arvalid=0, sfi_rsp_vld=0.
REQ-043 Req len=3, transid=0x5A, addr=0x1000 -> arid=0, arlen=3, araddr=0x1000; 4 R beats rid=0, rresp=0, rlast on beat 4 -> 4 rsp beats with transid 0x5A, last on 4th only, status=0.
REQ-044 DEPTH=4, arready=1, 5 back-to-back reqs -> arid 0..3 issued, sfi_req_rdy=0 after 4th; rlast for rid=2 -> 5th request issued with arid=2.
REQ-045 Reqs T0=0x10 (id0), T1=0x11 (id1); R for rid=1 first -> rsp transid 0x11 precedes 0x10.
REQ-046 R beat rid=3 with slot 3 free -> rready=1, sfi_rsp_vld=0, err_unexp=1 for one cycle.
REQ-047 len=3, rlast on beat 2 -> that beat has rsp_last=1 and status=1; slot freed.
